// File: rtl/si_packet_pkg.sv
// Shared definitions for the SI tag packet framing.
//   - Header constants as they appear in the 128-bit lanes (byte k = tdata[8*k +: 8]).
//   - Packet byte offsets of each header field.
//   - Generator FSM state enum.
//   - build_header_beat(): assembles header beat 0 (MACs, ethertype, 'SI') or
//     header beat 1 ('TT', version, type, little-endian sequence number).
package si_packet_pkg;

  localparam int unsigned BEAT_BYTES = 16;

  // Lane values: the low byte goes out first on the wire.
  localparam logic [15:0] ETHERTYPE = 16'h9B80;  // bytes 0x80, 0x9B
  localparam logic [15:0] MAGIC_SI  = 16'h4953;  // 'S', 'I'
  localparam logic [15:0] MAGIC_TT  = 16'h5454;  // 'T', 'T'
  localparam logic [7:0]  VERSION   = 8'h00;
  localparam logic [7:0]  TYPE      = 8'h00;

  // Byte offsets within the packet.
  localparam int unsigned OFF_DST_MAC   = 0;
  localparam int unsigned OFF_SRC_MAC   = 6;
  localparam int unsigned OFF_ETHERTYPE = 12;
  localparam int unsigned OFF_MAGIC_SI  = 14;
  localparam int unsigned OFF_MAGIC_TT  = 16;
  localparam int unsigned OFF_VERSION   = 18;
  localparam int unsigned OFF_TYPE      = 19;
  localparam int unsigned OFF_SEQUENCE  = 24;

  typedef enum logic [1:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StPayload
  } si_state_e;

  // beat_sel = 0 builds header beat 0, beat_sel = 1 builds header beat 1.
  function automatic logic [127:0] build_header_beat(input logic        beat_sel,
                                                     input logic [47:0] dst_mac,
                                                     input logic [47:0] src_mac,
                                                     input logic [31:0] seq);
    logic [127:0] beat;
    beat = '0;
    if (!beat_sel) begin
      // MACs go out most-significant byte first.
      for (int i = 0; i < 6; i++) begin
        beat[8*((OFF_DST_MAC + i) % BEAT_BYTES) +: 8] = dst_mac[8*(5-i) +: 8];
        beat[8*((OFF_SRC_MAC + i) % BEAT_BYTES) +: 8] = src_mac[8*(5-i) +: 8];
      end
      beat[8*(OFF_ETHERTYPE % BEAT_BYTES) +: 16] = ETHERTYPE;
      beat[8*(OFF_MAGIC_SI % BEAT_BYTES) +: 16]  = MAGIC_SI;
    end else begin
      beat[8*(OFF_MAGIC_TT % BEAT_BYTES) +: 16] = MAGIC_TT;
      beat[8*(OFF_VERSION % BEAT_BYTES) +: 8]   = VERSION;
      beat[8*(OFF_TYPE % BEAT_BYTES) +: 8]      = TYPE;
      beat[8*(OFF_SEQUENCE % BEAT_BYTES) +: 32] = seq;
    end
    return beat;
  endfunction

endpackage

// File: rtl/si_header_generator.sv
// SI header generator: prefixes each tag payload packet with a two-beat Ethernet/SI
// header and forwards the payload unchanged.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   s_axis_t{data,keep,valid,last,user}, s_axis_tready - payload stream in (tuser ignored)
//   m_axis_t{data,keep,valid,last,user}, m_axis_tready - framed packet out (tuser = 0)
//   dst_mac, src_mac              - MAC addresses, captured at packet start
//   sequence_num                  - sequence number the next packet will carry
//   packet_sent                   - high during the handshake of the last output beat
module si_header_generator
  import si_packet_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic                    s_axis_tready,

  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,

  input  logic [47:0]             dst_mac,
  input  logic [47:0]             src_mac,
  output logic [31:0]             sequence_num,
  output logic                    packet_sent
);

  if (DATA_WIDTH != 128) begin : gen_width_check
    $error("si_header_generator: DATA_WIDTH must be 128");
  end

  logic unused_tuser;
  assign unused_tuser = s_axis_tuser;

  // Reset asserts asynchronously, releases synchronously to clk.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

  si_state_e   state_q;
  logic [47:0] dst_q;
  logic [47:0] src_q;
  logic [31:0] hdr_seq_q;
  logic [31:0] seq_q;

  logic        last_hs;
  assign last_hs = (state_q == StPayload) && s_axis_tvalid && m_axis_tready && s_axis_tlast;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= StIdle;
      dst_q     <= '0;
      src_q     <= '0;
      hdr_seq_q <= '0;
      seq_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Wait for real payload so headers never go out ahead of it.
          if (s_axis_tvalid) begin
            dst_q     <= dst_mac;
            src_q     <= src_mac;
            hdr_seq_q <= seq_q;
            state_q   <= StHdr0;
          end
        end
        StHdr0: begin
          if (m_axis_tready) state_q <= StHdr1;
        end
        StHdr1: begin
          if (m_axis_tready) state_q <= StPayload;
        end
        StPayload: begin
          if (last_hs) begin
            seq_q   <= seq_q + 32'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [127:0] hdr0_beat;
  logic [127:0] hdr1_beat;
  assign hdr0_beat = build_header_beat(1'b0, dst_q, src_q, hdr_seq_q);
  assign hdr1_beat = build_header_beat(1'b1, dst_q, src_q, hdr_seq_q);

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tkeep  = s_axis_tkeep;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    packet_sent   = 1'b0;
    unique case (state_q)
      StHdr0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr0_beat;
        m_axis_tkeep  = '1;
      end
      StHdr1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr1_beat;
        m_axis_tkeep  = '1;
      end
      StPayload: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        packet_sent   = last_hs;
      end
      default: ;
    endcase
  end

  assign m_axis_tuser = 1'b0;
  assign sequence_num = seq_q;

endmodule

// File: tb/tb_si_header_generator.sv
// Self-checking bench for si_header_generator: scoreboard of expected output beats,
// random output backpressure, sequence wrap, and reset in the middle of a packet.
module tb_si_header_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tuser;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tuser;
  logic         m_tready;
  logic [47:0]  dst_mac;
  logic [47:0]  src_mac;
  logic [31:0]  sequence_num;
  logic         packet_sent;

  si_header_generator #(.DATA_WIDTH(128)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready),
    .dst_mac       (dst_mac),
    .src_mac       (src_mac),
    .sequence_num  (sequence_num),
    .packet_sent   (packet_sent)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_pulses  = 0;
  int          n_sent    = 0;
  int          ready_pct = 100;
  logic [31:0] exp_seq   = 32'd0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [47:0] rand48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected header beats, assembled byte by byte in wire order.
  function automatic logic [127:0] exp_hdr0(input logic [47:0] d, input logic [47:0] s);
    logic [7:0]   b[16];
    logic [127:0] r;
    for (int k = 0; k < 6; k++) begin
      b[k]     = d[47-8*k -: 8];
      b[6 + k] = s[47-8*k -: 8];
    end
    b[12] = 8'h80;
    b[13] = 8'h9B;
    b[14] = 8'h53;  // 'S'
    b[15] = 8'h49;  // 'I'
    for (int k = 0; k < 16; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  function automatic logic [127:0] exp_hdr1(input logic [31:0] seq);
    logic [7:0]   b[16];
    logic [127:0] r;
    for (int k = 0; k < 16; k++) b[k] = 8'h00;
    b[0]  = 8'h54;  // 'T'
    b[1]  = 8'h54;  // 'T'
    b[8]  = seq[7:0];
    b[9]  = seq[15:8];
    b[10] = seq[23:16];
    b[11] = seq[31:24];
    for (int k = 0; k < 16; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  task automatic push_beat(input logic [127:0] data, input logic [15:0] keep, input logic last);
    beat_t b;
    b.data = data;
    b.keep = keep;
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Output backpressure.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Output monitor: scoreboard compare on handshake, hold check while stalled.
  initial begin
    beat_t        b;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data  = '0;
    logic [15:0]  prev_keep  = '0;
    logic         prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (packet_sent) n_pulses++;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", m_tvalid, 1'b1);
          check_eq("hold_data", m_tdata, prev_data);
          check_eq("hold_keep", m_tkeep, prev_keep);
          check_eq("hold_last", m_tlast, prev_last);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check_eq("beat_expected", exp_q.size(), 1);
          end else begin
            b = exp_q.pop_front();
            check_eq("beat_data", m_tdata, b.data);
            check_eq("beat_keep", m_tkeep, b.keep);
            check_eq("beat_last", m_tlast, b.last);
            check_eq("beat_tuser", m_tuser, 1'b0);
            check_eq("packet_sent", packet_sent, b.last);
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_keep  = m_tkeep;
        prev_last  = m_tlast;
      end
    end
  end

  // Present one payload beat and wait for its handshake; cycles = clock edges spent.
  // With scramble set, the MAC inputs are changed once the header has been captured.
  task automatic drive_beat(input logic [127:0] data, input logic [15:0] keep,
                            input logic last, input bit scramble, output int cycles);
    int t = 0;
    s_tdata  = data;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tuser  = $urandom_range(1);
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      t++;
      if (s_tready) break;
      if (scramble && t >= 2) begin
        dst_mac = rand48();
        src_mac = rand48();
      end
      if (t >= 300) begin
        check_eq("drive_timeout", t, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    cycles   = t;
  endtask

  task automatic drive_packet(input int n, input logic [15:0] last_keep, output int cycles);
    logic [47:0]  d;
    logic [47:0]  s;
    logic [127:0] data;
    logic [15:0]  keep;
    int           c;
    d       = rand48();
    s       = rand48();
    dst_mac = d;
    src_mac = s;
    push_beat(exp_hdr0(d, s), 16'hFFFF, 1'b0);
    push_beat(exp_hdr1(exp_seq), 16'hFFFF, 1'b0);
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      data = rand128();
      keep = (i == n - 1) ? last_keep : 16'hFFFF;
      push_beat(data, keep, i == n - 1);
      drive_beat(data, keep, i == n - 1, i == 0, c);
      cycles += c;
    end
    exp_seq++;
    n_sent++;
    check_eq("sequence_num", sequence_num, exp_seq);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           c;
    int           w;
    logic [47:0]  d;
    logic [47:0]  s;
    logic [127:0] rd[5];

    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    dst_mac  = '0;
    src_mac  = '0;
    #3;
    check_eq("rst_m_tvalid", m_tvalid, 1'b0);
    check_eq("rst_s_tready", s_tready, 1'b0);
    check_eq("rst_sequence", sequence_num, 32'd0);
    check_eq("rst_packet_sent", packet_sent, 1'b0);
    check_eq("rst_m_tuser", m_tuser, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Full throughput: N payload beats cost N+3 cycles.
    drive_packet(1, 16'hFFFF, c);
    check_eq("cost_1beat", c, 4);
    drive_packet(4, 16'hFFFF, c);
    check_eq("cost_4beat", c, 7);
    drive_packet(2, 16'hFFFF, c);
    check_eq("cost_2beat", c, 5);
    @(negedge clk);
    check_eq("pulses_3", n_pulses, 3);

    // Backpressure with partial last-beat keep.
    ready_pct = 30;
    for (int i = 0; i < 6; i++) drive_packet($urandom_range(1, 6), 16'h00FF, c);

    // Sequence wrap.
    ready_pct = 70;
    force dut.seq_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.seq_q;
    exp_seq = 32'hFFFF_FFFE;
    check_eq("seq_forced", sequence_num, exp_seq);
    for (int i = 0; i < 3; i++) drive_packet(2, 16'hFFFF, c);
    check_eq("seq_wrapped", sequence_num, 32'd1);

    // Reset while beat 3 of a 5-beat payload is on the bus.
    ready_pct = 100;
    repeat (2) @(posedge clk);
    #1;
    d       = rand48();
    s       = rand48();
    dst_mac = d;
    src_mac = s;
    push_beat(exp_hdr0(d, s), 16'hFFFF, 1'b0);
    push_beat(exp_hdr1(exp_seq), 16'hFFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rd[i] = rand128();
      push_beat(rd[i], 16'hFFFF, i == 4);
    end
    drive_beat(rd[0], 16'hFFFF, 1'b0, 1'b0, c);
    drive_beat(rd[1], 16'hFFFF, 1'b0, 1'b0, c);
    s_tdata  = rd[2];
    s_tkeep  = 16'hFFFF;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_m_tvalid", m_tvalid, 1'b0);
    check_eq("midrst_s_tready", s_tready, 1'b0);
    check_eq("midrst_sequence", sequence_num, 32'd0);
    check_eq("midrst_packet_sent", packet_sent, 1'b0);
    exp_q.delete();
    exp_seq  = 32'd0;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    drive_packet(3, 16'hFFFF, c);
    check_eq("cost_after_reset", c, 6);

    // Random traffic.
    ready_pct = 50;
    for (int i = 0; i < 25; i++) begin
      drive_packet($urandom_range(1, 8), 16'(($urandom_range(65534)) + 1), c);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check_eq("pulse_count", n_pulses, n_sent);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
